// File: rtl/ef_i2s_pkg.sv
// Shared types and constants for the I2S receive sequencer.
package ef_i2s_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } i2s_state_e;

    // Configuration captured at run start and at every frame boundary.
    typedef struct packed {
        logic [7:0] prescale;
        logic [5:0] size;
        logic [1:0] channels;
        logic       sign_ext;
    } i2s_cfg_t;

    // Sample sizes of 0 or above one slot behave as a full 32-bit slot.
    function automatic logic [5:0] eff_size(input logic [5:0] s);
        return ((s == 6'd0) || (s > 6'd32)) ? 6'd32 : s;
    endfunction

endpackage

// File: rtl/ef_i2s_sck_gen.sv
// Bit-clock generator: divides clk_i by 2*(prescale+1) while active and
// flags the clk_i cycle that precedes each sck rising / falling edge.
module ef_i2s_sck_gen (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       active_i,
    input  logic [7:0] prescale_i,
    output logic       sck_o,
    output logic       rise_o,
    output logic       fall_o
);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic       tick;

    // The edge strobes are high in the cycle whose closing clk_i edge moves sck.
    assign tick   = active_i && (div_q >= prescale_i);
    assign rise_o = tick && !sck_q;
    assign fall_o = tick && sck_q;
    assign sck_o  = sck_q;

    // Next divider count and bit-clock level; inactive parks sck low.
    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (!active_i) begin
            div_d = 8'd0;
            sck_d = 1'b0;
        end else if (tick) begin
            div_d = 8'd0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // Divider and bit-clock registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/ef_i2s_rx_seq.sv
// I2S receive sequencer: generates sck/ws, deserialises sdi into
// right-aligned words and hands them out through a one-entry register.
//
// Output handshake: a word is transferred on a clk_i edge where
// valid_o & ready_i; while valid_o is high and ready_i low, sample_o,
// chan_o and valid_o hold. A new word arriving while the register is held
// is dropped and flagged by a single-cycle ovf_o.
module ef_i2s_rx_seq #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [7:0]    prescale_i,
    input  logic [5:0]    sample_size_i,
    input  logic [1:0]    channels_i,
    input  logic          sign_ext_i,
    output logic          sck_o,
    output logic          ws_o,
    input  logic          sdi_i,
    output logic [DW-1:0] sample_o,
    output logic          chan_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          ovf_o,
    output logic          busy_o
);

    import ef_i2s_pkg::*;

    i2s_state_e    state_q, state_d;
    i2s_cfg_t      cfg_q, cfg_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   sh_q, sh_d;
    logic          done_q, done_d, done_ch_q, done_ch_d;
    logic [DW-1:0] sample_q, sample_d, word;
    logic          chan_q, chan_d, valid_q, valid_d, ovf_q, ovf_d;
    logic          busy, load_cfg, frame_end, sck_rise, sck_fall, push, sbit;
    logic [5:0]    slot;

    ef_i2s_sck_gen u_sck_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active_i   (busy),
        .prescale_i (cfg_q.prescale),
        .sck_o      (sck_o),
        .rise_o     (sck_rise),
        .fall_o     (sck_fall)
    );

    assign slot      = {1'b0, bit_cnt_q[4:0]};
    assign frame_end = sck_fall && (bit_cnt_q == 6'(FRAME_BITS - 1));
    assign push      = done_q && cfg_q.channels[done_ch_q];

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: a stopped sequencer finishes its frame unless re-enabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_i) state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = ST_STOP;
            ST_STOP: begin
                if (frame_end) state_d = ST_IDLE;
                else if (en_i) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: activity flag and configuration capture points.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        load_cfg = ((state_q == ST_IDLE) && en_i) || frame_end;
    end

    // Completed word: low 'size' bits of the shifter, upper bits extended.
    always_comb begin
        word = '0;
        sbit = cfg_q.sign_ext && sh_q[5'(cfg_q.size - 6'd1)];
        for (int i = 0; i < DW; i++) begin
            if (i < int'(cfg_q.size)) word[i] = sh_q[5'(i % SLOT_BITS)];
            else                      word[i] = sbit;
        end
    end

    // Datapath next state: config, bit counter, shifter and output register.
    always_comb begin
        cfg_d = cfg_q;
        if (load_cfg) cfg_d = {prescale_i, eff_size(sample_size_i), channels_i, sign_ext_i};

        bit_cnt_d = bit_cnt_q;
        if (!busy)         bit_cnt_d = 6'd0;
        else if (sck_fall) bit_cnt_d = bit_cnt_q + 6'd1;

        sh_d      = sh_q;
        done_d    = 1'b0;
        done_ch_d = done_ch_q;
        if (sck_rise && (slot < cfg_q.size)) begin
            sh_d = {sh_q[30:0], sdi_i};
            if (slot == (cfg_q.size - 6'd1)) begin
                done_d    = 1'b1;
                done_ch_d = bit_cnt_q[5];
            end
        end

        sample_d = sample_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
        ovf_d    = 1'b0;
        if (push) begin
            if (valid_q && !ready_i) begin
                ovf_d = 1'b1;
            end else begin
                sample_d = word;
                chan_d   = done_ch_q;
                valid_d  = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers; reset drops partial and pending words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q     <= '0;
            bit_cnt_q <= 6'd0;
            sh_q      <= 32'd0;
            done_q    <= 1'b0;
            done_ch_q <= 1'b0;
            sample_q  <= '0;
            chan_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ws_o     = (bit_cnt_q >= 6'(SLOT_BITS - 1)) && (bit_cnt_q <= 6'(FRAME_BITS - 2));
    assign sample_o = sample_q;
    assign chan_o   = chan_q;
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = busy;

endmodule
